// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 16-bit ALU: decodes one instruction per handshake,
// reads operands from an 8x16 register file, writes results back and keeps Z/N/C flags.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_op,
  output logic        alu_ci,
  input  logic [15:0] alu_y,
  input  logic        alu_carry,
  output logic        flag_zero,
  output logic        flag_neg,
  output logic        flag_carry,
  output logic        busy,
  output logic        done,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] regs_q [8];
  logic        zero_q, neg_q, carry_q;

  logic [3:0]  func;
  logic [2:0]  rd, rs;
  logic        is_alu, is_ldi, is_carry_op, last_exec, wr_en;

  assign func = ir_q[15:12];
  assign rd   = ir_q[10:8];
  assign rs   = ir_q[7:5];

  assign is_alu      = (func != 4'd14) && (func != 4'd15);
  assign is_ldi      = (func == 4'd14);
  assign is_carry_op = (func == 4'd1) || (func == 4'd2) || (func == 4'd8) ||
                       (func == 4'd9) || (func == 4'd10);
  // Multiply holds EXEC for MUL_CYCLES cycles; everything else retires after one.
  assign last_exec   = (func != 4'd13) || (cnt_q >= 4'(MUL_CYCLES - 1));
  assign wr_en       = (state_q == StExec) && last_exec;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          ir_d    = instr;
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_alu) begin
          alu_a  = regs_q[rd];
          alu_b  = regs_q[rs];
          alu_op = {ir_q[11] & carry_q, func};
        end
        if (last_exec) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (wr_en) begin
      if (is_alu) begin
        regs_q[rd] <= alu_y;
        zero_q     <= (alu_y == 16'h0000);
        neg_q      <= alu_y[15];
        if (is_carry_op) begin
          carry_q <= alu_carry;
        end
      end else if (is_ldi) begin
        regs_q[rd] <= {{8{ir_q[7]}}, ir_q[7:0]};
      end
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign alu_ci      = carry_q;
  assign flag_zero   = zero_q;
  assign flag_neg    = neg_q;
  assign flag_carry  = carry_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: an ALU model drives alu_y/alu_carry, a reference
// model of the register file and flags feeds a scoreboard checked when done pulses.
module tb_alu_sequencer;

  localparam int unsigned MULC = 3;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [4:0]  alu_op;
  logic        alu_ci, alu_carry;
  logic        flag_zero, flag_neg, flag_carry;
  logic        busy, done;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_sequencer #(.MUL_CYCLES(MULC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_ci      (alu_ci),
    .alu_y       (alu_y),
    .alu_carry   (alu_carry),
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg),
    .flag_carry  (flag_carry),
    .busy        (busy),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {carry, result}
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op, input logic ci);
    logic [16:0] r;
    logic [15:0] p;
    p = a * b;
    case (op[3:0])
      4'd1:    r = {1'b0, a} + {1'b0, b} + {16'h0000, op[4] & ci};
      4'd2:    r = {1'b0, a} - {1'b0, b};
      4'd3:    r = {1'b0, a & b};
      4'd4:    r = {1'b0, a | b};
      4'd5:    r = {1'b0, a ^ b};
      4'd8:    r = {a[15], a[14:0], 1'b0};
      4'd9:    r = {a[0], 1'b0, a[15:1]};
      4'd10:   r = {1'b0, a} + 17'd1;
      4'd13:   r = {1'b0, p};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_y} = alu_f(alu_a, alu_b, alu_op, alu_ci);

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] val;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  op;
    logic        ci;
    logic        z;
    logic        n;
    logic        c;
    logic [4:0]  e;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [8];
  logic        m_z, m_n, m_c;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] op_rr(input logic [3:0] f, input logic c,
                                        input logic [2:0] rd, input logic [2:0] rs);
    return {f, c, rd, rs, 5'b00000};
  endfunction

  function automatic logic [15:0] op_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'hE, 1'b0, rd, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_z = 1'b0;
    m_n = 1'b0;
    m_c = 1'b0;
  endtask

  // Issue one instruction from a negedge with the DUT idle; returns at the negedge after done.
  task automatic run(input logic [15:0] ins);
    exp_t        e, g;
    logic [3:0]  f;
    logic [2:0]  rd, rs;
    logic [16:0] r;
    int          k;
    f = ins[15:12];
    rd = ins[10:8];
    rs = ins[7:5];
    e = '0;
    e.rd = rd;
    e.ci = m_c;
    e.e  = (f == 4'd13) ? 5'(MULC) : 5'd1;
    if (f <= 4'd13) begin
      e.a = m_regs[rd];
      e.b = m_regs[rs];
      e.op = {ins[11] & m_c, f};
      r = alu_f(e.a, e.b, e.op, m_c);
      m_regs[rd] = r[15:0];
      m_z = (r[15:0] == 16'h0000);
      m_n = r[15];
      if (f == 4'd1 || f == 4'd2 || f == 4'd8 || f == 4'd9 || f == 4'd10) m_c = r[16];
    end else if (f == 4'd14) begin
      m_regs[rd] = {{8{ins[7]}}, ins[7:0]};
    end
    e.val = m_regs[rd];
    e.z = m_z;
    e.n = m_n;
    e.c = m_c;
    sb.push_back(e);

    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    dbg_addr = rd;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
      if (i <= int'(e.e)) begin
        chk("exec_alu_a", 32'(alu_a), 32'(e.a));
        chk("exec_alu_b", 32'(alu_b), 32'(e.b));
        chk("exec_alu_op", 32'(alu_op), 32'(e.op));
        chk("exec_alu_ci", 32'(alu_ci), 32'(e.ci));
        chk("exec_ready_low", 32'(instr_ready), 32'd0);
      end
    end
    chk("done_latency", 32'(k), 32'(e.e) + 32'd1);
    g = sb.pop_front();
    chk("wb_value", 32'(dbg_data), 32'(g.val));
    chk("flag_zero", 32'(flag_zero), 32'(g.z));
    chk("flag_neg", 32'(flag_neg), 32'(g.n));
    chk("flag_carry", 32'(flag_carry), 32'(g.c));
    chk("done_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("ready_return", 32'(instr_ready), 32'd1);
    chk("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    model_reset();
    #12 rst_n = 1'b1;

    // Asynchronous reset pulse mid-cycle
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_ci", 32'(alu_ci), 32'd0);
    chk("rst_flags", {29'd0, flag_zero, flag_neg, flag_carry}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("rst_reg", 32'(dbg_data), 32'd0);
    end

    // LDI and ADD
    run(op_ldi(3'd1, 8'h7F));
    run(op_ldi(3'd2, 8'hFF));
    chk("ldi_sext", 32'(dbg_data), 32'h0000_FFFF);
    run(op_rr(4'd1, 1'b0, 3'd1, 3'd2));
    chk("add_result", 32'(dbg_data), 32'h0000_007E);
    chk("add_carry", 32'(flag_carry), 32'd1);

    // Carry-in path, then AND must leave carry alone
    run(op_rr(4'd1, 1'b1, 3'd1, 3'd2));
    chk("addc_result", 32'(dbg_data), 32'h0000_007E);
    run(op_rr(4'd3, 1'b0, 3'd1, 3'd2));
    chk("and_keeps_carry", 32'(flag_carry), 32'd1);

    // Multiply latency
    run(op_ldi(3'd3, 8'd3));
    run(op_ldi(3'd4, 8'd5));
    run(op_rr(4'd13, 1'b0, 3'd3, 3'd4));
    chk("mul_result", 32'(dbg_data), 32'd15);

    // Back-to-back: NOP then LDI r5 with instr_valid held high
    dbg_addr = 3'd5;
    instr_valid = 1'b1;
    instr = 16'hF000;
    @(posedge clk);
    #1 instr = op_ldi(3'd5, 8'h80);
    @(negedge clk);
    chk("hs_busy", 32'(busy), 32'd1);
    chk("hs_ready_t1", 32'(instr_ready), 32'd0);
    chk("nop_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_ready_t2", 32'(instr_ready), 32'd0);
    chk("nop_no_write", 32'(dbg_data), 32'(m_regs[5]));
    chk("nop_flags", {29'd0, flag_zero, flag_neg, flag_carry}, {29'd0, m_z, m_n, m_c});
    @(negedge clk);
    chk("hs_ready_t3", 32'(instr_ready), 32'd1);
    chk("hs_done_t3", 32'(done), 32'd0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    m_regs[5] = 16'hFF80;
    @(negedge clk);
    chk("hs_second_busy", 32'(busy), 32'd1);
    chk("hs_second_old", 32'(dbg_data), 32'd0);
    @(negedge clk);
    chk("hs_second_done", 32'(done), 32'd1);
    chk("hs_second_value", 32'(dbg_data), 32'(m_regs[5]));
    @(negedge clk);

    // Reset during EXEC cycle 2 of a multiply
    dbg_addr = 3'd3;
    instr_valid = 1'b1;
    instr = op_rr(4'd13, 1'b0, 3'd3, 3'd4);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(instr_ready), 32'd1);
    end
    chk("abort_r3", 32'(dbg_data), 32'd0);
    chk("abort_flags", {29'd0, flag_zero, flag_neg, flag_carry}, 32'd0);

    // rd == rs reads the pre-write value: 1 - 1 = 0 sets Zero
    run(op_ldi(3'd7, 8'h01));
    run(op_rr(4'd2, 1'b0, 3'd7, 3'd7));
    chk("sub_self_zero", 32'(flag_zero), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-level control block for the 16-bit datapath: accepts one 16-bit instruction per handshake, reads operands from an internal 8x16 register file, and drives the combinational ALU with A, B, aluOp and Ci. It writes the ALU result back and maintains the Zero/Neg/Carry flag register. It sits between instruction fetch and the ALU, as the issuing end of the ALU's operand/opcode interface.

## Interface
- `MUL_CYCLES`, default 2: number of EXEC cycles allowed for func 13 (multiply), legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: instruction available.
- `instr_ready` out 1: block can accept an instruction.
- `instr` in 16: instruction word.
- `alu_a` out 16: ALU operand A.
- `alu_b` out 16: ALU operand B.
- `alu_op` out 5: ALU aluOp.
- `alu_ci` out 1: ALU Ci; equals the stored carry flag.
- `alu_y` in 16: ALU result.
- `alu_carry` in 1: ALU carry out.
- `flag_zero` out 1: registered Zero flag.
- `flag_neg` out 1: registered Neg flag.
- `flag_carry` out 1: registered Carry flag.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when an instruction retires.
- `dbg_addr` in 3: debug register select.
- `dbg_data` out 16: combinational read of `R[dbg_addr]`.

## Operation
- Instruction format:
  - `[15:12]` func (= aluOp[3:0]).
  - `[11]` C: when 1, aluOp[4] = `flag_carry`; when 0, aluOp[4] = 0.
  - `[10:8]` rd.
  - `[7:5]` rs.
  - `[4:0]` ignored.
- Func 0..13 are ALU ops: A = R[rd], B = R[rs]; the result is written to R[rd].
- Func 14 is LDI: R[rd] = sign-extend(`instr[7:0]`). The ALU is not used, `alu_op` stays 0, and flags are unchanged.
- Func 15 is NOP: no write and no flag change; `done` still pulses.
- Flag update on ALU ops only:
  - `flag_zero` = (`alu_y` == 0).
  - `flag_neg` = `alu_y[15]`.
  - `flag_carry` = `alu_carry` for func 1, 2, 8, 9, 10; unchanged for all other funcs.
- rd == rs is legal; both operands read the pre-write value.
- State machine:
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr` into IR, clear the cycle counter, go to EXEC.
  - EXEC: drive `alu_a`/`alu_b`/`alu_op` from IR.
    - Func 13: stay while counter < `MUL_CYCLES`-1, incrementing each cycle.
    - Other funcs: one cycle.
    - On the final EXEC edge, write R[rd] and flags, then go to DONE.
  - DONE: `done`=1, then go to IDLE.
- Outside EXEC, `alu_a`, `alu_b` and `alu_op` are 0. `alu_ci` always mirrors `flag_carry`.
- Reset values:
  - R0..R7, IR, counter, all flags: 0.
  - State: IDLE.
  - `done`=0, `busy`=0, `instr_ready`=1 once `rst_n` is high.
  - `alu_a`, `alu_b`, `alu_op`: 0.
- Reset asserted mid-instruction aborts immediately: no register or flag write, no `done`.

## Timing
- Accept edge at T. EXEC occupies cycles T+1 .. T+E, where E=1, or E=`MUL_CYCLES` for func 13.
- Register/flag write occurs on the edge ending cycle T+E. `done` is high during cycle T+E+1.
- `dbg_data` reflects the new R[rd] from cycle T+E+1.
- Throughput: one instruction per E+2 cycles. `instr_ready` is low from T+1 through T+E+1 and returns high at T+E+2.
- `instr` is sampled only on the accept edge; changes while busy are ignored.
- `instr_valid` held high while not ready is legal; the instruction is accepted on the first ready cycle.

## Test plan
- Reset: pulse `rst_n` low asynchronously mid-cycle.
  - Required: all outputs, R0..R7 and flags read 0; `instr_ready`=1.
- LDI and ADD:
  - LDI r1,0x7F, then LDI r2,0xFF (sign-extended to 0xFFFF), then ADD r1,r2.
  - Required: `alu_a`=0x007F, `alu_b`=0xFFFF and `alu_op`=5'h01 during EXEC; `done` at accept+2; R1 = `alu_y`; flags as ALU reports.
- Carry-in path:
  - Force model `alu_carry`=1 on ADD, then issue ADD with C=1.
  - Required: `alu_op`=5'h11; `alu_ci`=1; `flag_carry` unchanged by a following AND (func 3).
- Multiply latency:
  - With `MUL_CYCLES`=3, issue func 13 r3,r4 (R3=3, R4=5).
  - Required: EXEC for 3 cycles; `done` at accept+4; R3=15 with a correct ALU model.
- Handshake:
  - Hold `instr_valid`=1 with two queued instructions.
  - Required: second accepted exactly at accept+3; `instr` changes while busy have no effect; NOP pulses `done` with no register/flag change.
- Reset mid-multiply:
  - Assert `rst_n` low during EXEC cycle 2 of a multiply.
  - Required: no `done`; R3 = 0; state IDLE after release.
